// File: rtl/get_data_pipe.sv
// -----------------------------------------------------------------------------
// get_data_pipe
//
// Clocked fetch stage sitting between get_param and the Occ lookup. One
// parameter set (i, z, k, l, addr, position) is accepted per transaction over
// a valid/ready handshake. The position code is decoded into reads of rom_C
// and/or rom_read_and_D (synchronous ROMs with ROM_LAT clocks of latency).
// The returned data is captured and presented as one registered result with
// its own valid/ready handshake. get_data_in_Occ flags results that must visit
// the Occ stage.
//
// Optional feature (macro GET_DATA_STALL_CNT_EN): adds the stall_cnt output,
// a saturating count of cycles spent in HOLD while downstream is not ready.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid / in_ready          input handshake
//   i_in, z_in, k_in, l_in       search parameters (IDX_W)
//   addr_in                      parameter address tag (ADDR_W)
//   position_in                  execution position code (POS_W)
//   ce_rom_C, addr_rom_C         rom_C enable / address (SYM_W)
//   ce_rom_read_and_D,
//   addr_rom_read_and_D          rom_read_and_D enable / address (IDX_W)
//   data                         rom_C read data
//   d_i, read_i                  rom_read_and_D read data (D value, symbol)
//   out_valid / out_ready        output handshake
//   i_out .. position_out        passthrough of the accepted set
//   d_i_out, read_i_out, C_out   captured ROM data (0 where not fetched)
//   get_data_in_Occ              result requires the Occ stage
//   stall_cnt                    (GET_DATA_STALL_CNT_EN only) HOLD stall count
//
// Position codes
//   0        NONE
//   1..4     A/C/G/T_INSERTION
//   5..8     A/C/G/T_DELETION
//   9..12    A/C/G/T_MATCH, 13..16 A/C/G/T_SNP, 17 STOP_1, 18 STOP_2
//   others   undefined (treated like the no-ROM positions)
// -----------------------------------------------------------------------------
module get_data_pipe #(
    parameter int IDX_W   = 8,
    parameter int ADDR_W  = 12,
    parameter int POS_W   = 5,
    parameter int DATA_W  = 8,
    parameter int SYM_W   = 2,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  i_in,
    input  logic [IDX_W-1:0]  z_in,
    input  logic [IDX_W-1:0]  k_in,
    input  logic [IDX_W-1:0]  l_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [POS_W-1:0]  position_in,
    output logic              ce_rom_C,
    output logic [SYM_W-1:0]  addr_rom_C,
    output logic              ce_rom_read_and_D,
    output logic [IDX_W-1:0]  addr_rom_read_and_D,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] d_i,
    input  logic [SYM_W-1:0]  read_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  i_out,
    output logic [IDX_W-1:0]  z_out,
    output logic [IDX_W-1:0]  k_out,
    output logic [IDX_W-1:0]  l_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [POS_W-1:0]  position_out,
    output logic [DATA_W-1:0] d_i_out,
    output logic [SYM_W-1:0]  read_i_out,
    output logic [DATA_W-1:0] C_out,
    output logic              get_data_in_Occ
`ifdef GET_DATA_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [POS_W-1:0] POS_NONE        = POS_W'(0);
    localparam logic [POS_W-1:0] POS_A_INSERTION = POS_W'(1);
    localparam logic [POS_W-1:0] POS_C_INSERTION = POS_W'(2);
    localparam logic [POS_W-1:0] POS_G_INSERTION = POS_W'(3);
    localparam logic [POS_W-1:0] POS_T_INSERTION = POS_W'(4);
    localparam logic [POS_W-1:0] POS_A_DELETION  = POS_W'(5);
    localparam logic [POS_W-1:0] POS_C_DELETION  = POS_W'(6);
    localparam logic [POS_W-1:0] POS_G_DELETION  = POS_W'(7);
    localparam logic [POS_W-1:0] POS_T_DELETION  = POS_W'(8);

    // Wide enough for ROM_LAT-1 with ROM_LAT up to 4.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic             ce_c;
        logic             ce_d;
        logic [SYM_W-1:0] sym;
        logic             occ;
    } dec_t;

    function automatic dec_t decode(input logic [POS_W-1:0] pos);
        dec_t r;
        r = '0;
        case (pos)
            POS_NONE:        r.ce_d = 1'b1;
            POS_A_INSERTION: begin r.ce_c = 1'b1; r.sym = SYM_W'(0); r.occ = 1'b1; end
            POS_C_INSERTION: begin r.ce_c = 1'b1; r.sym = SYM_W'(1); r.occ = 1'b1; end
            POS_G_INSERTION: begin r.ce_c = 1'b1; r.sym = SYM_W'(2); r.occ = 1'b1; end
            POS_T_INSERTION: begin r.ce_c = 1'b1; r.sym = SYM_W'(3); r.occ = 1'b1; end
            POS_A_DELETION:  begin r.ce_c = 1'b1; r.ce_d = 1'b1; r.sym = SYM_W'(0); r.occ = 1'b1; end
            POS_C_DELETION:  begin r.ce_c = 1'b1; r.ce_d = 1'b1; r.sym = SYM_W'(1); r.occ = 1'b1; end
            POS_G_DELETION:  begin r.ce_c = 1'b1; r.ce_d = 1'b1; r.sym = SYM_W'(2); r.occ = 1'b1; end
            POS_T_DELETION:  begin r.ce_c = 1'b1; r.ce_d = 1'b1; r.sym = SYM_W'(3); r.occ = 1'b1; end
            default:         r = '0;
        endcase
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    i_q, i_d, z_q, z_d, k_q, k_d, l_q, l_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                ce_c_q, ce_c_d, ce_d_q, ce_d_d;
    logic [SYM_W-1:0]    addr_c_q, addr_c_d;
    logic [IDX_W-1:0]    addr_dr_q, addr_dr_d;
    logic [DATA_W-1:0]   d_i_q, d_i_d, c_q, c_d;
    logic [SYM_W-1:0]    read_i_q, read_i_d;
    logic                occ_q, occ_d;
    logic                out_valid_q, out_valid_d;

    logic                accept;
    dec_t                dec_in;

    assign in_ready = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
    assign accept   = in_valid & in_ready;
    assign dec_in   = decode(position_in);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        i_d         = i_q;
        z_d         = z_q;
        k_d         = k_q;
        l_d         = l_q;
        addr_d      = addr_q;
        pos_d       = pos_q;
        ce_c_d      = ce_c_q;
        ce_d_d      = ce_d_q;
        addr_c_d    = addr_c_q;
        addr_dr_d   = addr_dr_q;
        d_i_d       = d_i_q;
        c_d         = c_q;
        read_i_d    = read_i_q;
        occ_d       = occ_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = CNT_W'(ROM_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    // Last WAIT edge: the ROM outputs are valid now. The
                    // enable pattern tells which fields this position keeps.
                    state_d     = S_HOLD;
                    out_valid_d = 1'b1;
                    ce_c_d      = 1'b0;
                    ce_d_d      = 1'b0;
                    if (ce_c_q)
                        c_d = data;
                    if (ce_c_q & ce_d_q)
                        read_i_d = read_i;
                    if (ce_d_q & ~ce_c_q)
                        d_i_d = d_i;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (out_ready & ~in_valid) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // A new set can arrive from IDLE or from HOLD while the current
        // result is being taken; either way it overrides the above.
        if (accept) begin
            i_d       = i_in;
            z_d       = z_in;
            k_d       = k_in;
            l_d       = l_in;
            addr_d    = addr_in;
            pos_d     = position_in;
            d_i_d     = '0;
            c_d       = '0;
            read_i_d  = '0;
            occ_d     = dec_in.occ;
            ce_c_d    = dec_in.ce_c;
            ce_d_d    = dec_in.ce_d;
            addr_c_d  = dec_in.ce_c ? dec_in.sym : '0;
            addr_dr_d = dec_in.ce_d ? i_in : '0;
            if (dec_in.ce_c | dec_in.ce_d) begin
                state_d     = S_ISSUE;
                out_valid_d = 1'b0;
            end else begin
                state_d     = S_HOLD;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            i_q         <= '0;
            z_q         <= '0;
            k_q         <= '0;
            l_q         <= '0;
            addr_q      <= '0;
            pos_q       <= '0;
            ce_c_q      <= 1'b0;
            ce_d_q      <= 1'b0;
            addr_c_q    <= '0;
            addr_dr_q   <= '0;
            d_i_q       <= '0;
            c_q         <= '0;
            read_i_q    <= '0;
            occ_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            i_q         <= i_d;
            z_q         <= z_d;
            k_q         <= k_d;
            l_q         <= l_d;
            addr_q      <= addr_d;
            pos_q       <= pos_d;
            ce_c_q      <= ce_c_d;
            ce_d_q      <= ce_d_d;
            addr_c_q    <= addr_c_d;
            addr_dr_q   <= addr_dr_d;
            d_i_q       <= d_i_d;
            c_q         <= c_d;
            read_i_q    <= read_i_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ce_rom_C            = ce_c_q;
    assign addr_rom_C          = addr_c_q;
    assign ce_rom_read_and_D   = ce_d_q;
    assign addr_rom_read_and_D = addr_dr_q;
    assign out_valid           = out_valid_q;
    assign i_out               = i_q;
    assign z_out               = z_q;
    assign k_out               = k_q;
    assign l_out               = l_q;
    assign addr_out            = addr_q;
    assign position_out        = pos_q;
    assign d_i_out             = d_i_q;
    assign read_i_out          = read_i_q;
    assign C_out               = c_q;
    assign get_data_in_Occ     = occ_q;

`ifdef GET_DATA_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_HOLD) && !out_ready && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule
